// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared sprite geometry, frame-buffer sizes and blitter states.
//  Revision    : 1.0  initial release
// ============================================================================
package sprite_pkg;

    localparam int SPR_W      = 90;
    localparam int SPR_H      = 90;
    localparam int FB_W       = 640;
    localparam int FB_H       = 480;
    localparam int IDX_W      = 3;
    localparam int FB_ADDR_W  = 19;
    localparam int ROM_ADDR_W = 13;
    localparam int COL_W      = 7;
    localparam int COORD_W    = 12;

    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/blit_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : blit_coord_gen
//  Description : Sprite pixel counters, screen clipping and ROM/FB addressing.
//  Revision    : 1.0  initial release
// ============================================================================
module blit_coord_gen
    import sprite_pkg::*;
(
    input  logic                  vga_clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic signed [10:0]    pos_x,
    input  logic signed [10:0]    pos_y,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic                  on_screen,
    output logic                  last_pixel
);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(SPR_W - 1);
    localparam logic [COL_W-1:0] c_row_last = COL_W'(SPR_H - 1);

    logic [COL_W-1:0]   r_col;
    logic [COL_W-1:0]   r_row;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [COORD_W-1:0] w_sx;
    logic [COORD_W-1:0] w_sy;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
            r_x0  <= '0;
            r_y0  <= '0;
        end else if (load) begin
            r_col <= '0;
            r_row <= '0;
            r_x0  <= {pos_x[10], pos_x} - COORD_W'(SPR_W / 2);
            r_y0  <= {pos_y[10], pos_y} - COORD_W'(SPR_H / 2);
        end else if (advance) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                // Wrap the row too so the idle ROM address rests at 0.
                r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign w_sx = r_x0 + COORD_W'(r_col);
    assign w_sy = r_y0 + COORD_W'(r_row);

    // Bit 11 is the sign; once clear, an unsigned compare gives the upper bound.
    assign on_screen = !w_sx[COORD_W-1] && (w_sx < COORD_W'(FB_W)) &&
                       !w_sy[COORD_W-1] && (w_sy < COORD_W'(FB_H));

    assign fb_addr    = on_screen ? (FB_ADDR_W'(w_sy) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(w_sx))
                                  : '0;
    assign rom_addr   = ROM_ADDR_W'(r_row) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(r_col);
    assign last_pixel = (r_col == c_col_last) && (r_row == c_row_last);

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Copies opaque, on-screen sprite ROM pixels into the frame buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic                  vga_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [10:0]    pos_x,
    input  logic signed [10:0]    pos_y,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]      rom_q,
    output logic                  fb_we,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [IDX_W-1:0]      fb_data,
    input  logic                  fb_ready,
    output logic                  busy,
    output logic                  done
);

    blit_state_t             r_state;
    blit_state_t             w_next;
    logic                    w_load;
    logic                    w_advance;
    logic                    w_issue;
    logic                    w_on_screen;
    logic                    w_last;
    logic [FB_ADDR_W-1:0]    w_fb_addr;
    logic                    r_fb_we;
    logic [FB_ADDR_W-1:0]    r_fb_addr;
    logic [IDX_W-1:0]        r_fb_data;

    blit_coord_gen u_coord (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .load       (w_load),
        .advance    (w_advance),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .rom_addr   (rom_addr),
        .fb_addr    (w_fb_addr),
        .on_screen  (w_on_screen),
        .last_pixel (w_last)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if ((rom_q != TRANSPARENT_IDX) && w_on_screen) begin
                    w_issue = 1'b1;
                    w_next  = ST_WRITE;
                end else begin
                    w_advance = 1'b1;
                    w_next    = w_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_WRITE: begin
                if (fb_ready) begin
                    w_advance = 1'b1;
                    w_next    = w_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Write request is held untouched until the arbiter takes it.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else if (w_issue) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_fb_addr;
            r_fb_data <= rom_q;
        end else if ((r_state == ST_WRITE) && fb_ready) begin
            r_fb_we   <= 1'b0;
        end
    end

    assign fb_we   = r_fb_we;
    assign fb_addr = r_fb_addr;
    assign fb_data = r_fb_data;
    assign busy    = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_WRITE);
    assign done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_blitter
//  Description : Randomised self-checking bench for sprite_blitter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_blitter;

    logic               vga_clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [10:0] pos_x;
    logic signed [10:0] pos_y;
    logic [12:0]        rom_addr;
    logic [2:0]         rom_q;
    logic               fb_we;
    logic [18:0]        fb_addr;
    logic [2:0]         fb_data;
    logic               fb_ready;
    logic               busy;
    logic               done;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] rom_mem [0:8099];

    int exp_addr[$];
    int exp_data[$];
    int exp_cycles;

    int got_writes, bad_writes, got_cycles, done_pulses, busy_err, hold_err;
    int max_addr, first_addr, last_addr, zero_data;

    sprite_blitter dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk)
        rom_q <= (rom_addr < 13'd8100) ? rom_mem[rom_addr] : 3'd0;

    // Reference: raster walk of the sprite, 3 cycles per written pixel, 2 per skip.
    task automatic build_model(input int px, input int py, input bit stall);
        exp_addr.delete();
        exp_data.delete();
        exp_cycles = 0;
        for (int r = 0; r < 90; r++) begin
            for (int c = 0; c < 90; c++) begin
                int sx, sy, v;
                sx = px - 45 + c;
                sy = py - 45 + r;
                v  = int'(rom_mem[r * 90 + c]);
                if (v != 0 && sx >= 0 && sx < 640 && sy >= 0 && sy < 480) begin
                    exp_addr.push_back(sy * 640 + sx);
                    exp_data.push_back(v);
                    exp_cycles += 3;
                end else begin
                    exp_cycles += 2;
                end
            end
        end
        if (stall) exp_cycles += 4 * (exp_addr.size() / 3);
    endtask

    task automatic run_blit(input int px, input int py, input bit stall, input int extra_start_at);
        int cyc, stall_cnt, limit;
        logic [18:0] hold_a;
        logic [2:0]  hold_d;
        bit exp_busy;
        build_model(px, py, stall);
        got_writes = 0; bad_writes = 0; got_cycles = -1; done_pulses = 0;
        busy_err = 0; hold_err = 0; max_addr = 0; first_addr = -1; last_addr = -1;
        zero_data = 0; stall_cnt = 0; hold_a = '0; hold_d = '0;
        limit = exp_cycles + 300;
        @(negedge vga_clk);
        pos_x    = px[10:0];
        pos_y    = py[10:0];
        start    = 1'b1;
        fb_ready = 1'b1;
        @(negedge vga_clk);
        cyc = 0;
        while (cyc < limit) begin
            start    = (cyc == extra_start_at);
            exp_busy = (got_cycles < 0) && !done;
            if (busy !== exp_busy) busy_err++;
            if (done) begin
                done_pulses++;
                if (got_cycles < 0) got_cycles = cyc;
            end
            if (fb_we) begin
                if (stall && (got_writes % 3 == 2) && stall_cnt < 4) begin
                    if (stall_cnt == 0) begin
                        hold_a = fb_addr;
                        hold_d = fb_data;
                    end else if (fb_addr !== hold_a || fb_data !== hold_d) begin
                        hold_err++;
                    end
                    stall_cnt++;
                    fb_ready = 1'b0;
                end else begin
                    if (stall_cnt > 0 && (fb_addr !== hold_a || fb_data !== hold_d)) hold_err++;
                    stall_cnt = 0;
                    fb_ready  = 1'b1;
                    if (got_writes < exp_addr.size()) begin
                        if (int'(fb_addr) != exp_addr[got_writes] ||
                            int'(fb_data) != exp_data[got_writes]) bad_writes++;
                    end else begin
                        bad_writes++;
                    end
                    if (fb_data == 3'd0) zero_data++;
                    if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
                    if (first_addr < 0) first_addr = int'(fb_addr);
                    last_addr = int'(fb_addr);
                    got_writes++;
                end
            end else begin
                fb_ready = 1'($urandom_range(1, 0));
            end
            if (got_cycles >= 0 && cyc >= got_cycles + 4) break;
            @(negedge vga_clk);
            cyc++;
        end
        start    = 1'b0;
        fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; fb_ready = 1'b1; pos_x = '0; pos_y = '0;
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (fb_we !== 1'b0) $display("FAIL reset_fb_we got %b want 0", fb_we); else n_pass++;
        n_total++; if (fb_addr !== 19'd0) $display("FAIL reset_fb_addr got %0d want 0", fb_addr); else n_pass++;
        n_total++; if (fb_data !== 3'd0) $display("FAIL reset_fb_data got %0d want 0", fb_data); else n_pass++;
        n_total++; if (rom_addr !== 13'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else n_pass++;
    endtask

    task automatic test_centre();
        for (int i = 0; i < 8100; i++) rom_mem[i] = 3'd5;
        run_blit(320, 240, 1'b0, -1);
        n_total++; if (got_writes != 8100) $display("FAIL centre_count got %0d want 8100", got_writes); else n_pass++;
        n_total++; if (bad_writes != 0) $display("FAIL centre_writes got %0d bad want 0", bad_writes); else n_pass++;
        n_total++; if (first_addr != 125075) $display("FAIL centre_first got %0d want 125075", first_addr); else n_pass++;
        n_total++; if (last_addr != 182124) $display("FAIL centre_last got %0d want 182124", last_addr); else n_pass++;
        n_total++; if (got_cycles != 24300) $display("FAIL centre_cycles got %0d want 24300", got_cycles); else n_pass++;
        n_total++; if (done_pulses != 1) $display("FAIL centre_done got %0d want 1", done_pulses); else n_pass++;
        n_total++; if (busy_err != 0) $display("FAIL centre_busy got %0d errors want 0", busy_err); else n_pass++;
    endtask

    task automatic test_transparency_busy_start();
        for (int i = 0; i < 8100; i++) rom_mem[i] = ((i % 90) % 2 == 0) ? 3'd0 : 3'd3;
        run_blit(320, 240, 1'b0, 700);
        n_total++; if (got_writes != 4050) $display("FAIL transp_count got %0d want 4050", got_writes); else n_pass++;
        n_total++; if (zero_data != 0) $display("FAIL transp_zero_data got %0d want 0", zero_data); else n_pass++;
        n_total++; if (bad_writes != 0) $display("FAIL transp_writes got %0d bad want 0", bad_writes); else n_pass++;
        n_total++; if (got_cycles != 20250) $display("FAIL transp_cycles got %0d want 20250", got_cycles); else n_pass++;
        n_total++; if (done_pulses != 1) $display("FAIL busy_start_done got %0d want 1", done_pulses); else n_pass++;
    endtask

    task automatic test_clip_backpressure();
        for (int i = 0; i < 8100; i++) rom_mem[i] = 3'($urandom_range(7, 1));
        run_blit(10, 470, 1'b1, -1);
        n_total++; if (got_writes != 3025) $display("FAIL clip_count got %0d want 3025", got_writes); else n_pass++;
        n_total++; if (bad_writes != 0) $display("FAIL clip_writes got %0d bad want 0", bad_writes); else n_pass++;
        n_total++; if (max_addr >= 307200) $display("FAIL clip_max_addr got %0d want <307200", max_addr); else n_pass++;
        n_total++; if (hold_err != 0) $display("FAIL stall_hold got %0d errors want 0", hold_err); else n_pass++;
        n_total++; if (got_cycles != exp_cycles) $display("FAIL stall_cycles got %0d want %0d", got_cycles, exp_cycles); else n_pass++;
        n_total++; if (done_pulses != 1) $display("FAIL stall_done got %0d want 1", done_pulses); else n_pass++;
    endtask

    task automatic test_reset_mid_blit();
        int wr, cyc, late_done, late_we, late_busy;
        for (int i = 0; i < 8100; i++) rom_mem[i] = 3'($urandom_range(7, 1));
        @(negedge vga_clk);
        pos_x = 11'sd320; pos_y = 11'sd240; start = 1'b1; fb_ready = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        wr = 0; cyc = 0;
        while (wr < 1000 && cyc < 5000) begin
            if (fb_we) wr++;
            if (wr < 1000) begin
                @(negedge vga_clk);
                cyc++;
            end
        end
        n_total++; if (wr != 1000) $display("FAIL rst_mid_reach got %0d writes want 1000", wr); else n_pass++;
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        n_total++;
        if ({busy, done, fb_we} !== 3'b000 || fb_addr !== 19'd0 || fb_data !== 3'd0 || rom_addr !== 13'd0)
            $display("FAIL rst_mid_outputs got busy=%b done=%b we=%b addr=%0d data=%0d rom=%0d want all 0",
                     busy, done, fb_we, fb_addr, fb_data, rom_addr);
        else n_pass++;
        late_done = 0; late_we = 0; late_busy = 0;
        repeat (40) begin
            @(negedge vga_clk);
            if (done) late_done++;
            if (fb_we) late_we++;
            if (busy) late_busy++;
        end
        n_total++; if (late_done != 0) $display("FAIL rst_mid_done got %0d want 0", late_done); else n_pass++;
        n_total++; if (late_we + late_busy != 0) $display("FAIL rst_mid_idle got %0d active want 0", late_we + late_busy); else n_pass++;
    endtask

    task automatic test_offscreen_after_reset();
        run_blit(-100, -100, 1'b0, -1);
        n_total++; if (got_writes != 0) $display("FAIL offscreen_count got %0d want 0", got_writes); else n_pass++;
        n_total++; if (got_cycles != 16200) $display("FAIL offscreen_cycles got %0d want 16200", got_cycles); else n_pass++;
        n_total++; if (done_pulses != 1) $display("FAIL offscreen_done got %0d want 1", done_pulses); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_centre();
        test_transparency_busy_start();
        test_clip_backpressure();
        test_reset_mid_blit();
        test_offscreen_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer-side counterpart to the sprite ROM/palette display path.
- On a start pulse, walks a 90x90 palette-indexed sprite ROM and writes every opaque, on-screen pixel into the palette-index frame buffer, centred at (pos_x, pos_y).
- Sits between game logic (issues start and position) and the frame-buffer write port, which an arbiter shares with the display reader.

Parameters:
- SPR_W, 90, sprite width in pixels
- SPR_H, 90, sprite height in pixels
- FB_W, 640, frame-buffer width
- FB_H, 480, frame-buffer height
- IDX_W, 3, palette index width
- TRANSPARENT_IDX, 0, index never written to the frame buffer

Ports:
- vga_clk  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a blit; sampled only in IDLE
- pos_x  in  11  signed sprite centre X, latched at start
- pos_y  in  11  signed sprite centre Y, latched at start
- rom_addr  out  13  sprite ROM address (row*SPR_W + col)
- rom_q  in  IDX_W  ROM data, one-cycle synchronous latency
- fb_we  out  1  frame-buffer write request
- fb_addr  out  19  y*FB_W + x
- fb_data  out  IDX_W  palette index to write
- fb_ready  in  1  arbiter accepts the write this cycle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: every output goes to 0 (busy, done, fb_we, fb_addr, fb_data, rom_addr). State goes to IDLE. Counters col and row clear.
- Reset mid-blit: same as above. No done pulse. Any pending write is abandoned.
- Start sampling:
  - start is ignored unless the state is IDLE.
  - On start in IDLE, latch x0 = pos_x - SPR_W/2 and y0 = pos_y - SPR_H/2 (signed 12-bit), clear col and row, go to FETCH.
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
- FETCH: rom_addr = row*SPR_W + col. Go to WAIT.
- WAIT:
  - rom_q is valid. Compute sx = x0+col and sy = y0+row.
  - The pixel is skipped if rom_q == TRANSPARENT_IDX, sx<0, sx>=FB_W, sy<0 or sy>=FB_H.
  - If not skipped: register fb_addr = sy*FB_W+sx, fb_data = rom_q, fb_we = 1, go to WRITE.
  - If skipped: advance the pixel and go to FETCH, or to DONE if it was the last pixel.
- WRITE:
  - Hold fb_we, fb_addr and fb_data stable until fb_ready = 1.
  - In the accept cycle, drop fb_we on the next edge, advance the pixel, and go to FETCH or DONE.
- Pixel advance:
  - col increments; at SPR_W-1 it wraps to 0 and row increments.
  - The last pixel is col = SPR_W-1, row = SPR_H-1.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- start is accepted again in the IDLE cycle after DONE, i.e. 2 cycles after the final write is accepted.
- Throughput with fb_ready tied high:
  - 3 cycles per written pixel, 2 per skipped pixel.
  - A fully opaque, fully visible sprite takes 24300 cycles from start to done.
- Arithmetic:
  - Screen coordinates are signed 12-bit.
  - fb_addr multiply uses an unsigned 19-bit product; it is only formed for in-range coordinates.
  - rom_addr max 8099 fits in 13 bits.
- Writes are never issued out of raster order, and the same address is never written twice in one blit.

Decomposition:
- Shared package sprite_pkg:
  - state enum blit_state_t
  - SPR_W, SPR_H, FB_W, FB_H, IDX_W, TRANSPARENT_IDX
  - FB_ADDR_W = 19, ROM_ADDR_W = 13
- The same package is used by the display-side sprite logic.
- Sub-module blit_coord_gen holds:
  - col/row counters, last-pixel flag
  - signed screen-coordinate and clip computation
  - rom_addr and fb_addr generation
- The top level keeps the FSM and the handshake registers.

Test Plan:
- Centre blit: pos=(320,240), all-opaque ROM (index 5), fb_ready=1.
  - Expect 8100 writes; first fb_addr = 195*640+275 = 125075, last = 284*640+364 = 182124, all data 5.
  - done exactly 24300 cycles after start.
- Transparency: ROM index 0 at even columns, 3 elsewhere.
  - Expect 4050 writes, none with data 0, duration 8100*2 + 4050 cycles.
- Clipping: pos=(10,470).
  - Only sx in 0..54 and sy in 425..479 are written; 55*55 = 3025 writes.
  - No fb_addr is ever >= 307200.
- Backpressure: fb_ready low 4 cycles on every 3rd write.
  - fb_we, fb_addr and fb_data stay stable while stalled; write count unchanged; done delayed accordingly.
- Start/reset edge cases:
  - A start pulse during busy is ignored: one done only.
  - Reset asserted at pixel 1000: all outputs are 0 next cycle, no done.
  - A new start after reset completes normally.
- Off-screen: pos=(-100,-100).
  - Zero writes; done after 16200 cycles.
